case10_stim_gen: RTL and testbench

//   Sequential stimulus source sitting directly upstream of the case10 combinational netlist.

---
 rtl/case10_stim_gen_if.sv | 24 ++
 rtl/case10_stim_gen.sv | 111 +++++++++++
 tb/tb_case10_stim_gen.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/case10_stim_gen_if.sv
// Stimulus bus between case10_stim_gen and the capture stage that samples y1/y2.
// The master drives vectors and position counters; the slave returns out_ready.
interface case10_stim_gen_if #(
  parameter int unsigned PASS_W = 4
) ();
  logic              out_valid;
  logic              out_ready;
  logic              a;
  logic              b;
  logic              c;
  logic              d;
  logic [3:0]        vec_idx;
  logic [PASS_W-1:0] pass_idx;

  modport master (
    output out_valid, a, b, c, d, vec_idx, pass_idx,
    input  out_ready
  );

  modport slave (
    input  out_valid, a, b, c, d, vec_idx, pass_idx,
    output out_ready
  );
endinterface

// File: rtl/case10_stim_gen.sv
// Sweeps all 16 {a,b,c,d} codes in count, Gray or LFSR order, NUM_PASSES times per start,
// under a valid/ready handshake; pulses o_done once the final vector is accepted.
module case10_stim_gen #(
  parameter int unsigned NUM_PASSES = 1,
  parameter int unsigned PASS_W     = 4,
  parameter logic [3:0]  LFSR_SEED  = 4'b1001
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [1:0]        i_mode,
  output logic              o_busy,
  output logic              o_done,
  case10_stim_gen_if.master bus
);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  localparam logic [PASS_W-1:0] LastPass = PASS_W'(NUM_PASSES - 1);
  // An all-zero seed would lock the LFSR, so it is replaced by 0001.
  localparam logic [3:0]        Seed     = (LFSR_SEED == 4'b0000) ? 4'b0001 : LFSR_SEED;

  state_e            r_state, w_state_d;
  logic [1:0]        r_mode, w_mode_d;
  logic [3:0]        r_vec, w_vec_d;
  logic [3:0]        r_lfsr, w_lfsr_d;
  logic [PASS_W-1:0] r_pass, w_pass_d;
  logic              w_run;
  logic              w_hs;
  logic [3:0]        w_v;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_mode  <= 2'b00;
      r_vec   <= 4'd0;
      r_lfsr  <= Seed;
      r_pass  <= '0;
    end else begin
      r_state <= w_state_d;
      r_mode  <= w_mode_d;
      r_vec   <= w_vec_d;
      r_lfsr  <= w_lfsr_d;
      r_pass  <= w_pass_d;
    end
  end

  assign w_run = (r_state == StRun);
  assign w_hs  = w_run & bus.out_ready;

  always_comb begin
    w_state_d = r_state;
    w_mode_d  = r_mode;
    w_vec_d   = r_vec;
    w_lfsr_d  = r_lfsr;
    w_pass_d  = r_pass;
    case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_d = StRun;
          w_mode_d  = i_mode;
          w_vec_d   = 4'd0;
          w_pass_d  = '0;
          w_lfsr_d  = Seed;
        end
      end
      StRun: begin
        if (w_hs) begin
          if (r_vec == 4'd15) begin
            if (r_pass == LastPass) begin
              w_state_d = StFin;
            end else begin
              w_pass_d = r_pass + 1'b1;
              w_vec_d  = 4'd0;
              w_lfsr_d = Seed;
            end
          end else begin
            w_vec_d  = r_vec + 4'd1;
            w_lfsr_d = {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
          end
        end
      end
      StFin: begin
        w_state_d = StIdle;
        w_vec_d   = 4'd0;
        w_pass_d  = '0;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Slot 15 of an LFSR pass emits 0000, the one code the LFSR never reaches.
  always_comb begin
    w_v = 4'b0000;
    if (w_run) begin
      case (r_mode)
        2'b01:   w_v = r_vec ^ (r_vec >> 1);
        2'b10:   w_v = (r_vec == 4'd15) ? 4'b0000 : r_lfsr;
        default: w_v = r_vec;
      endcase
    end
  end

  assign bus.out_valid                 = w_run;
  assign {bus.a, bus.b, bus.c, bus.d}  = w_v;
  assign bus.vec_idx                   = r_vec;
  assign bus.pass_idx                  = r_pass;
  assign o_busy                        = w_run;
  assign o_done                        = (r_state == StFin);

endmodule

// File: tb/tb_case10_stim_gen.sv
// Randomized bench for case10_stim_gen: two instances (1 and 3 passes) share rst/mode/ready
// and are compared against an expected-vector queue built from the sweep rules.
module tb_case10_stim_gen;

  typedef struct {
    int pass;
    int vec;
    int v;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start0;
  logic       start1;
  logic       ready;
  logic [1:0] mode;
  logic       busy0, done0, busy1, done1;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t q0[$];
  exp_t q1[$];

  case10_stim_gen_if #(.PASS_W(4)) if0 ();
  case10_stim_gen_if #(.PASS_W(4)) if1 ();

  assign if0.out_ready = ready;
  assign if1.out_ready = ready;

  case10_stim_gen #(.NUM_PASSES(1), .PASS_W(4), .LFSR_SEED(4'b1001)) u_dut0 (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start0),
    .i_mode  (mode),
    .o_busy  (busy0),
    .o_done  (done0),
    .bus     (if0)
  );

  case10_stim_gen #(.NUM_PASSES(3), .PASS_W(4), .LFSR_SEED(4'b1001)) u_dut1 (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start1),
    .i_mode  (mode),
    .o_busy  (busy1),
    .o_done  (done1),
    .bus     (if1)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Vector number i of a pass, from the ordering rules.
  function automatic int ref_v(input int md, input int i);
    int s;
    s = 9;
    if (md == 1) return i ^ (i >> 1);
    if (md == 2) begin
      if (i == 15) return 0;
      for (int k = 0; k < i; k++) s = ((s * 2) % 16) + (((s / 8) + (s / 4)) % 2);
      return s;
    end
    return i;
  endfunction

  task automatic chk_one(input string nm, input bit has, input exp_t e, input bit fin_exp,
                         input bit rst_exp, input logic vld, input logic [3:0] v,
                         input logic [3:0] vi, input logic [3:0] pi, input logic bsy,
                         input logic dn);
    check_eq({nm, ".valid"}, vld, int'(has));
    check_eq({nm, ".busy"}, bsy, int'(has));
    check_eq({nm, ".done"}, dn, int'(fin_exp));
    if (has) begin
      check_eq({nm, ".vec"}, v, e.v);
      check_eq({nm, ".vec_idx"}, vi, e.vec);
      check_eq({nm, ".pass_idx"}, pi, e.pass);
    end else begin
      check_eq({nm, ".vec_idle"}, v, 0);
    end
    if (rst_exp) begin
      check_eq({nm, ".rst_vec_idx"}, vi, 0);
      check_eq({nm, ".rst_pass_idx"}, pi, 0);
    end
  endtask

  // rmode: 0 ready always, 1 ready toggles starting high, 2 random ready.
  task automatic run(input int md, input int rmode, input bit mid_start, input bit rst_mid);
    int         c, idle, done_c;
    bit         fin0, fin1, f0, f1, jr;
    logic [15:0] mask0;
    exp_t       e, e0, e1, none;
    none = '{0, 0, 0};
    q0.delete();
    q1.delete();
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 16; i++) begin
        e = '{p, i, ref_v(md, i)};
        if (p == 0) q0.push_back(e);
        q1.push_back(e);
      end
    end
    mode   = 2'(md);
    start0 = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    mode   = 2'($urandom_range(0, 3));
    c = 1; idle = 0; done_c = 0; fin0 = 0; fin1 = 0; jr = 0; mask0 = '0;
    while (idle < 3 && c < 400) begin
      e0 = none;
      e1 = none;
      if (q0.size() > 0) e0 = q0[0];
      if (q1.size() > 0) e1 = q1[0];
      chk_one("d0", q0.size() > 0, e0, fin0, jr, if0.out_valid, {if0.a, if0.b, if0.c, if0.d},
              if0.vec_idx, if0.pass_idx, busy0, done0);
      chk_one("d1", q1.size() > 0, e1, fin1, jr, if1.out_valid, {if1.a, if1.b, if1.c, if1.d},
              if1.vec_idx, if1.pass_idx, busy1, done1);
      if (fin0) begin
        done_c = c;
        check_eq("d0.all_codes", mask0, 16'hffff);
      end
      f0 = fin0; f1 = fin1;
      fin0 = 0; fin1 = 0; jr = 0;
      if (rst) rst = 1'b0;
      if (rst_mid && q0.size() > 0 && q0[0].vec == 7) begin
        rst = 1'b1;
        q0.delete();
        q1.delete();
        jr = 1;
      end
      case (rmode)
        0:       ready = 1'b1;
        1:       ready = (c % 2 == 1);
        default: ready = ($urandom_range(0, 2) != 0);
      endcase
      // Extra starts land only while running or in FIN, where they must be ignored.
      start0 = mid_start && (f0 || (q0.size() > 0 && $urandom_range(0, 7) == 0));
      start1 = mid_start && (f1 || (q1.size() > 0 && $urandom_range(0, 7) == 0));
      if (ready && q0.size() > 0) begin
        mask0[{if0.a, if0.b, if0.c, if0.d}] = 1'b1;
        void'(q0.pop_front());
        if (q0.size() == 0) fin0 = 1;
      end
      if (ready && q1.size() > 0) begin
        void'(q1.pop_front());
        if (q1.size() == 0) fin1 = 1;
      end
      if (q0.size() == 0 && q1.size() == 0 && !fin0 && !fin1) idle++;
      @(negedge clk);
      c++;
    end
    start0 = 1'b0;
    start1 = 1'b0;
    check_eq("timeout", int'(c < 400), 1);
    if (!rst_mid && rmode == 0) check_eq("d0.done_latency", done_c, 17);
    if (!rst_mid && rmode == 1) check_eq("d0.done_latency", done_c, 32);
  endtask

  initial begin
    exp_t none;
    none   = '{0, 0, 0};
    rst    = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    ready  = 1'b0;
    mode   = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_one("rst0", 1'b0, none, 1'b0, 1'b1, if0.out_valid, {if0.a, if0.b, if0.c, if0.d},
            if0.vec_idx, if0.pass_idx, busy0, done0);
    chk_one("rst1", 1'b0, none, 1'b0, 1'b1, if1.out_valid, {if1.a, if1.b, if1.c, if1.d},
            if1.vec_idx, if1.pass_idx, busy1, done1);
    rst = 1'b0;
    @(negedge clk);
    run(0, 0, 1'b0, 1'b0);
    run(1, 0, 1'b0, 1'b0);
    run(2, 0, 1'b0, 1'b0);
    run(0, 1, 1'b0, 1'b0);
    run(2, 2, 1'b1, 1'b0);
    run(1, 2, 1'b1, 1'b0);
    run(3, 2, 1'b1, 1'b0);
    run(0, 0, 1'b0, 1'b1);
    run(0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) run(int'($urandom_range(0, 3)), 2, 1'b1, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
